// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the SRAM port arbiter slice.
package arm_mem_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LINE_W     = 64;
    localparam int DEF_FAIR_LIMIT = 4;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Grant decision between I and D with a saturating fairness counter that
// forces an I grant after FAIR_LIMIT consecutive D grants while I waits.
module sram_arb_pick
    import arm_mem_pkg::*;
#(
    parameter int FAIR_LIMIT = DEF_FAIR_LIMIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_i,
    input  logic       req_d,
    input  logic       grant,
    output logic       grant_d,
    output logic [3:0] fair_cnt
);

    localparam logic [3:0] LIMIT = 4'(FAIR_LIMIT);

    // Data wins a collision unless instruction fetch has waited long enough.
    always_comb begin
        grant_d = PORT_I;
        if (req_d && req_i) begin
            grant_d = (fair_cnt == LIMIT) ? PORT_I : PORT_D;
        end else if (req_d) begin
            grant_d = PORT_D;
        end else begin
            grant_d = PORT_I;
        end
    end

    // Counter only moves on the cycle a grant is actually issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fair_cnt <= 4'd0;
        end else if (grant) begin
            if ((grant_d == PORT_D) && req_i) begin
                fair_cnt <= (fair_cnt == LIMIT) ? LIMIT : fair_cnt + 4'd1;
            end else begin
                fair_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller between instruction fetch and data ports,
// running a single IDLE -> BUSY -> RESP transaction at a time.
module sram_port_arbiter
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_W     = DEF_LINE_W,
    parameter int FAIR_LIMIT = DEF_FAIR_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [LINE_W-1:0] d_rdata,
    output logic              sram_re,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic              sram_ready,
    input  logic [LINE_W-1:0] sram_rdata,
    output logic              busy,
    output logic              grant_d
);

    arb_state_t state;
    arb_state_t state_next;
    logic       req_d;
    logic       pick_d;
    logic       pick_wr;
    logic       grant_stb;
    logic       done;
    logic       op_write;
    logic [3:0] unused_fair_cnt;

    assign req_d   = d_re | d_we;
    assign pick_wr = (pick_d == PORT_D) & d_we;

    sram_arb_pick #(
        .FAIR_LIMIT(FAIR_LIMIT)
    ) u_pick (
        .clk      (clk),
        .rst      (rst),
        .req_i    (i_req),
        .req_d    (req_d),
        .grant    (grant_stb),
        .grant_d  (pick_d),
        .fair_cnt (unused_fair_cnt)
    );

    // Next-state decode; requests are only looked at while IDLE.
    always_comb begin
        state_next = state;
        grant_stb  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || req_d) begin
                    grant_stb  = 1'b1;
                    state_next = BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (sram_ready) begin
                    done       = 1'b1;
                    state_next = RESP;
                end else begin
                    state_next = BUSY;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered SRAM interface, acks and read-line capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_re    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            op_write   <= 1'b0;
            grant_d    <= 1'b0;
            busy       <= 1'b0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    if (grant_stb) begin
                        sram_addr <= (pick_d == PORT_D) ? d_addr : i_addr;
                        if (pick_wr) begin
                            sram_wdata <= d_wdata;
                        end
                        op_write <= pick_wr;
                        sram_we  <= pick_wr;
                        sram_re  <= ~pick_wr;
                        grant_d  <= pick_d;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    if (done) begin
                        sram_re <= 1'b0;
                        sram_we <= 1'b0;
                        i_ack   <= (grant_d == PORT_I);
                        d_ack   <= (grant_d == PORT_D);
                        if (!op_write) begin
                            if (grant_d == PORT_D) begin
                                d_rdata <= sram_rdata;
                            end else begin
                                i_rdata <= sram_rdata;
                            end
                        end
                    end
                end
                RESP: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    sram_re <= 1'b0;
                    sram_we <= 1'b0;
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: vector table, ack scoreboard,
// and hand-written sequences for reset, collision, fairness and back-to-back.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [63:0] i_rdata;
    logic        d_re;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [63:0] d_rdata;
    logic        sram_re;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_ready;
    logic [63:0] sram_rdata;
    logic        busy;
    logic        grant_d;

    typedef struct {
        logic        port_d;
        logic        is_write;
        logic [63:0] rdata;
    } sb_t;

    typedef struct {
        logic        i_req;
        logic        d_re;
        logic        d_we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        exp_re;
        logic        exp_we;
        logic [31:0] exp_wdata;
        int          exp_ack_cyc;
    } vec_t;

    sb_t         sb[$];
    vec_t        vecs[6];
    int          total = 0;
    int          bad = 0;
    int          lat = 1;
    int          wcnt = 0;
    logic [63:0] exp_i_rdata = 64'd0;
    logic [63:0] exp_d_rdata = 64'd0;
    logic        chk_fair = 1'b0;
    int          max_fc = 0;

    sram_port_arbiter u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ack      (i_ack),
        .i_rdata    (i_rdata),
        .d_re       (d_re),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .sram_re    (sram_re),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_ready (sram_ready),
        .sram_rdata (sram_rdata),
        .busy       (busy),
        .grant_d    (grant_d)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_line(input logic [31:0] a);
        if (a == 32'h0000_0100) return 64'hDEAD_BEEF_CAFE_F00D;
        return {a | 32'hC0DE_0000, ~a};
    endfunction

    assign sram_rdata = model_line(sram_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SRAM controller model: ready rises after 'lat' low cycles of an access.
    always @(negedge clk) begin
        if (sram_re || sram_we) begin
            sram_ready = (wcnt >= lat);
            wcnt++;
        end else begin
            sram_ready = 1'b0;
            wcnt = 0;
        end
    end

    // Scoreboard: every ack pops the oldest expected transaction.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (chk_fair) begin
                if (int'(u_dut.u_pick.fair_cnt) > max_fc) max_fc = int'(u_dut.u_pick.fair_cnt);
                chk("fair_cnt_le_limit", {63'd0, (u_dut.u_pick.fair_cnt <= 4'd4)}, 64'd1);
            end
            if (i_ack || d_ack) begin
                chk("single_ack", {63'd0, i_ack & d_ack}, 64'd0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: got i_ack=%0b d_ack=%0b, want none", i_ack, d_ack);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", {63'd0, d_ack}, {63'd0, e.port_d});
                    if (e.port_d) begin
                        if (!e.is_write) exp_d_rdata = e.rdata;
                    end else begin
                        exp_i_rdata = e.rdata;
                    end
                    chk("d_rdata", d_rdata, exp_d_rdata);
                    chk("i_rdata", i_rdata, exp_i_rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        int   cyc;
        int   acks;
        logic dseen;
        logic iseen;

        rst = 1'b1; i_req = 1'b0; i_addr = 32'd0; d_re = 1'b0; d_we = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0;
        repeat (2) tick();
        chk("rst_sram_re", {63'd0, sram_re}, 64'd0);
        chk("rst_sram_we", {63'd0, sram_we}, 64'd0);
        chk("rst_sram_addr", {32'd0, sram_addr}, 64'd0);
        chk("rst_sram_wdata", {32'd0, sram_wdata}, 64'd0);
        chk("rst_i_rdata", i_rdata, 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        chk("rst_acks", {62'd0, i_ack, d_ack}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_grant_d", {63'd0, grant_d}, 64'd0);
        rst = 1'b0;

        //           i_req d_re  d_we  addr          wdata         lat re    we    exp_wdata     ack
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 5, 1'b1, 1'b0, 32'h0000_0000, 7};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 0, 1'b1, 1'b0, 32'h0000_0000, 2};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'hA5A5_0001, 2, 1'b0, 1'b1, 32'hA5A5_0001, 4};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0050, 32'h0000_5555, 1, 1'b0, 1'b1, 32'h0000_5555, 3};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0000_BBBB, 3, 1'b1, 1'b0, 32'h0000_5555, 5};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0048, 32'hFFFF_0000, 1, 1'b1, 1'b0, 32'h0000_5555, 3};

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            lat = v.lat;
            i_req = v.i_req; d_re = v.d_re; d_we = v.d_we; d_wdata = v.wdata;
            if (v.i_req) i_addr = v.addr;
            else d_addr = v.addr;
            sb.push_back('{port_d: v.d_re | v.d_we, is_write: v.d_we, rdata: model_line(v.addr)});
            tick();
            cyc = 1;
            chk("vec_addr", {32'd0, sram_addr}, {32'd0, v.addr});
            chk("vec_wdata", {32'd0, sram_wdata}, {32'd0, v.exp_wdata});
            chk("vec_grant_d", {63'd0, grant_d}, {63'd0, v.d_re | v.d_we});
            while (!(i_ack || d_ack) && cyc < 100) begin
                chk("vec_sram_re", {63'd0, sram_re}, {63'd0, v.exp_re});
                chk("vec_sram_we", {63'd0, sram_we}, {63'd0, v.exp_we});
                tick();
                cyc++;
            end
            chk("vec_ack_cycle", 64'(cyc), 64'(v.exp_ack_cyc));
            i_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
            tick();
            chk("vec_idle_busy", {63'd0, busy}, 64'd0);
            chk("vec_idle_enables", {62'd0, sram_re, sram_we}, 64'd0);
        end

        // Reset while an access is stuck in BUSY.
        d_re = 1'b1; d_addr = 32'h0000_0040; lat = 1000;
        tick();
        chk("rmid_sram_re_on", {63'd0, sram_re}, 64'd1);
        repeat (2) tick();
        chk("rmid_busy_on", {63'd0, busy}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rmid_sram_re_drop", {63'd0, sram_re}, 64'd0);
        chk("rmid_busy", {63'd0, busy}, 64'd0);
        chk("rmid_d_ack", {63'd0, d_ack}, 64'd0);
        chk("rmid_d_rdata", d_rdata, 64'd0);
        chk("rmid_i_rdata", i_rdata, 64'd0);
        exp_d_rdata = 64'd0;
        exp_i_rdata = 64'd0;
        d_re = 1'b0; lat = 1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rmid_no_ack", {63'd0, d_ack}, 64'd0);
        end

        // Simultaneous I read and D write: D first, then I.
        lat = 2;
        i_addr = 32'h0000_0120; i_req = 1'b1;
        d_addr = 32'h0000_0008; d_wdata = 32'h0000_1234; d_we = 1'b1;
        sb.push_back('{port_d: 1'b1, is_write: 1'b1, rdata: 64'd0});
        sb.push_back('{port_d: 1'b0, is_write: 1'b0, rdata: model_line(32'h0000_0120)});
        tick();
        chk("sim_sram_we", {63'd0, sram_we}, 64'd1);
        chk("sim_sram_re", {63'd0, sram_re}, 64'd0);
        chk("sim_wdata", {32'd0, sram_wdata}, 64'h1234);
        chk("sim_addr", {32'd0, sram_addr}, 64'h8);
        chk("sim_grant_d", {63'd0, grant_d}, 64'd1);
        cyc = 0; dseen = 1'b0; iseen = 1'b0;
        while (cyc < 100) begin
            tick();
            cyc++;
            if (d_ack) begin d_we = 1'b0; dseen = 1'b1; end
            if (i_ack) begin i_req = 1'b0; iseen = 1'b1; break; end
        end
        chk("sim_d_done", {63'd0, dseen}, 64'd1);
        chk("sim_i_done", {63'd0, iseen}, 64'd1);
        tick();

        // Fairness with both ports permanently requesting.
        lat = 1;
        i_addr = 32'h0000_0200; d_addr = 32'h0000_0300;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) sb.push_back('{port_d: 1'b0, is_write: 1'b0, rdata: model_line(32'h0000_0200)});
            else sb.push_back('{port_d: 1'b1, is_write: 1'b0, rdata: model_line(32'h0000_0300)});
        end
        max_fc = 0; chk_fair = 1'b1;
        i_req = 1'b1; d_re = 1'b1;
        acks = 0; cyc = 0;
        while (acks < 10 && cyc < 500) begin
            tick();
            cyc++;
            if (i_ack || d_ack) acks++;
        end
        i_req = 1'b0; d_re = 1'b0;
        chk_fair = 1'b0;
        chk("fair_ack_count", 64'(acks), 64'd10);
        chk("fair_cnt_peak", 64'(max_fc), 64'd4);
        tick();

        // Back-to-back D reads with d_re held across the ack.
        lat = 2;
        d_re = 1'b1; d_addr = 32'h0000_0010;
        sb.push_back('{port_d: 1'b1, is_write: 1'b0, rdata: model_line(32'h0000_0010)});
        sb.push_back('{port_d: 1'b1, is_write: 1'b0, rdata: model_line(32'h0000_0018)});
        tick();
        chk("b2b_re1", {63'd0, sram_re}, 64'd1);
        chk("b2b_addr1", {32'd0, sram_addr}, 64'h10);
        d_addr = 32'h0000_0018;
        cyc = 0;
        while (!d_ack && cyc < 100) begin tick(); cyc++; end
        chk("b2b_ack1", {63'd0, d_ack}, 64'd1);
        chk("b2b_resp_busy", {63'd0, busy}, 64'd1);
        chk("b2b_addr_latched", {32'd0, sram_addr}, 64'h10);
        tick();
        chk("b2b_idle_re", {63'd0, sram_re}, 64'd0);
        chk("b2b_idle_busy", {63'd0, busy}, 64'd0);
        tick();
        chk("b2b_re2", {63'd0, sram_re}, 64'd1);
        chk("b2b_addr2", {32'd0, sram_addr}, 64'h18);
        chk("b2b_grant_d", {63'd0, grant_d}, 64'd1);
        cyc = 0;
        while (!d_ack && cyc < 100) begin tick(); cyc++; end
        chk("b2b_ack2", {63'd0, d_ack}, 64'd1);
        d_re = 1'b0;
        repeat (3) tick();
        chk("b2b_final_busy", {63'd0, busy}, 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
